sample_byte_packer: RTL and testbench

//  Consumer end of the filter output interface (18-bit sample + 1-cycle valid strobe).

---
 rtl/filt_pkg.sv | 12 +
 rtl/sample_fifo.sv | 60 ++++++
 rtl/sample_byte_packer.sv | 126 ++++++++++++
 tb/tb_sample_byte_packer.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/filt_pkg.sv
// filt_pkg: shared sample width, byte tags and packer state type for the filter output path
package filt_pkg;
    localparam int SAMPLE_W = 18;
    localparam logic [1:0] TAG_B0 = 2'b10;
    localparam logic [1:0] TAG_B1 = 2'b00;
    localparam logic [1:0] TAG_B2 = 2'b01;
    localparam logic [7:0] SYNC_BYTE = 8'hFF;
    typedef enum logic [2:0] {ST_IDLE, ST_SYNC, ST_B0, ST_B1, ST_B2} packer_state_t;
    function automatic logic [7:0] tag_byte(input logic [1:0] tag, input logic [5:0] bits);
        return {tag, bits};
    endfunction
endpackage

// File: rtl/sample_fifo.sv
// sample_fifo: power-of-2 sample buffer with registered read on pop and a combinational head peek
module sample_fifo
    import filt_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int W = SAMPLE_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             wr_data,
    input  logic                     pop,
    output logic [W-1:0]             head,
    output logic [W-1:0]             rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic [W-1:0]  rd_data_q, rd_data_d;

    // pointers wrap naturally at DEPTH; the level counter tracks occupancy
    always_comb begin
        wr_ptr_d  = wr_ptr_q + AW'(push);
        rd_ptr_d  = rd_ptr_q + AW'(pop);
        level_d   = level_q + LW'(push) - LW'(pop);
        rd_data_d = pop ? mem_q[rd_ptr_q] : rd_data_q;
    end

    // control state register
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            rd_data_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            rd_data_q <= rd_data_d;
        end
    end

    // storage array, no reset needed since level gates every read
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_data;
    end

    assign head    = mem_q[rd_ptr_q];
    assign rd_data = rd_data_q;
    assign full    = level_q == LW'(DEPTH);
    assign empty   = level_q == '0;
    assign level   = level_q;
endmodule

// File: rtl/sample_byte_packer.sv
// sample_byte_packer: buffers 18-bit samples and streams each as 3 tagged bytes; SAMPLE_PACKER_SYNC_EN adds periodic 8'hFF sync bytes
module sample_byte_packer
    import filt_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int FRAME_LEN = 64,
    parameter int DROP_W    = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [SAMPLE_W-1:0]    sample_in,
    input  logic                   sample_valid,
    output logic [7:0]             tx_data,
    output logic                   tx_valid,
    input  logic                   tx_ready,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic                   overflow,
    output logic [DROP_W-1:0]      drop_count
);
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || FRAME_LEN < 1) begin : g_bad_param
        $error("sample_byte_packer: DEPTH must be a power of 2 >= 2 and FRAME_LEN >= 1");
    end

    logic                push, pop, drop, full, empty, hs;
    logic [SAMPLE_W-1:0] head, hold;
    packer_state_t       state_q, state_d;
    logic                tx_valid_q, tx_valid_d;
    logic [7:0]          tx_data_q, tx_data_d;
    logic                overflow_q, overflow_d;
    logic [DROP_W-1:0]   drop_count_q, drop_count_d;
`ifdef SAMPLE_PACKER_SYNC_EN
    localparam int FW = FRAME_LEN > 1 ? $clog2(FRAME_LEN) : 1;
    logic [FW-1:0] frame_cnt_q, frame_cnt_d;
`endif

    sample_fifo #(.DEPTH(DEPTH), .W(SAMPLE_W)) u_fifo (
        .clk(clk), .rst(rst), .push(push), .wr_data(sample_in), .pop(pop),
        .head(head), .rd_data(hold), .full(full), .empty(empty), .level(fifo_level)
    );

    // the source cannot stall, so a push while full (pre-edge) is dropped and counted
    always_comb begin
        drop         = sample_valid && full;
        push         = sample_valid && !full;
        overflow_d   = overflow_q | drop;
        drop_count_d = drop_count_q + DROP_W'(drop && !(&drop_count_q));
    end

    // byte sequencer: pop in IDLE, then present each byte until it is accepted
    always_comb begin
        state_d    = state_q;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        pop        = 1'b0;
        hs         = tx_valid_q && tx_ready;
`ifdef SAMPLE_PACKER_SYNC_EN
        frame_cnt_d = frame_cnt_q;
`endif
        case (state_q)
            ST_IDLE: if (!empty) begin
                pop        = 1'b1;
                tx_valid_d = 1'b1;
`ifdef SAMPLE_PACKER_SYNC_EN
                state_d    = frame_cnt_q == '0 ? ST_SYNC : ST_B0;
                tx_data_d  = frame_cnt_q == '0 ? SYNC_BYTE : tag_byte(TAG_B0, head[17:12]);
`else
                state_d    = ST_B0;
                tx_data_d  = tag_byte(TAG_B0, head[17:12]);
`endif
            end
`ifdef SAMPLE_PACKER_SYNC_EN
            ST_SYNC: if (hs) begin
                state_d   = ST_B0;
                tx_data_d = tag_byte(TAG_B0, hold[17:12]);
            end
`endif
            ST_B0: if (hs) begin
                state_d   = ST_B1;
                tx_data_d = tag_byte(TAG_B1, hold[11:6]);
            end
            ST_B1: if (hs) begin
                state_d   = ST_B2;
                tx_data_d = tag_byte(TAG_B2, hold[5:0]);
            end
            ST_B2: if (hs) begin
                state_d    = ST_IDLE;
                tx_valid_d = 1'b0;
`ifdef SAMPLE_PACKER_SYNC_EN
                frame_cnt_d = frame_cnt_q == FW'(FRAME_LEN - 1) ? '0 : frame_cnt_q + FW'(1);
`endif
            end
            default: begin
                state_d    = ST_IDLE;
                tx_valid_d = 1'b0;
            end
        endcase
    end

    // output and sequencer registers; reset abandons any byte in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            tx_valid_q   <= 1'b0;
            tx_data_q    <= '0;
            overflow_q   <= 1'b0;
            drop_count_q <= '0;
`ifdef SAMPLE_PACKER_SYNC_EN
            frame_cnt_q  <= '0;
`endif
        end else begin
            state_q      <= state_d;
            tx_valid_q   <= tx_valid_d;
            tx_data_q    <= tx_data_d;
            overflow_q   <= overflow_d;
            drop_count_q <= drop_count_d;
`ifdef SAMPLE_PACKER_SYNC_EN
            frame_cnt_q  <= frame_cnt_d;
`endif
        end
    end

    assign tx_valid   = tx_valid_q;
    assign tx_data    = tx_data_q;
    assign overflow   = overflow_q;
    assign drop_count = drop_count_q;
endmodule

// File: tb/tb_sample_byte_packer.sv
// tb_sample_byte_packer: queue-based model of the byte stream plus directed scenarios with literal expectations
module tb_sample_byte_packer;
    localparam int DEPTH = 16;
    localparam int FRAME_LEN = 4;
    localparam int DROP_W = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [17:0] sample_in = '0;
    logic        sample_valid = 1'b0;
    logic        tx_ready = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic [4:0]  fifo_level;
    logic        overflow;
    logic [15:0] drop_count;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit armed = 0;

    logic [17:0] m_fifo[$];
    logic [7:0]  m_bytes[$];
    bit          m_ovf;
    int          m_drop;
    int          m_started;
    logic [7:0]  q_out[$];
    int          q_cyc[$];

    sample_byte_packer #(.DEPTH(DEPTH), .FRAME_LEN(FRAME_LEN), .DROP_W(DROP_W)) dut (
        .clk(clk), .rst(rst), .sample_in(sample_in), .sample_valid(sample_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .fifo_level(fifo_level), .overflow(overflow), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out (cycle %0d)", name, cyc);
    endtask

    // model: a sample queue feeds a queue of pending bytes; a new sample is taken only when no byte is pending
    always @(posedge clk) begin : model
        bit idle;
        bit was_full;
        logic [17:0] s;
        cyc++;
        if (rst) begin
            m_fifo.delete();
            m_bytes.delete();
            m_ovf = 0;
            m_drop = 0;
            m_started = 0;
            armed = 1;
        end else begin
            idle = m_bytes.size() == 0;
            was_full = m_fifo.size() == DEPTH;
            if (!idle && tx_ready) void'(m_bytes.pop_front());
            if (idle && m_fifo.size() > 0) begin
                s = m_fifo.pop_front();
`ifdef SAMPLE_PACKER_SYNC_EN
                if (m_started % FRAME_LEN == 0) m_bytes.push_back(8'hFF);
`endif
                m_bytes.push_back({2'b10, s[17:12]});
                m_bytes.push_back({2'b00, s[11:6]});
                m_bytes.push_back({2'b01, s[5:0]});
                m_started++;
            end
            if (sample_valid) begin
                if (was_full) begin
                    m_ovf = 1;
                    if (m_drop < (1 << DROP_W) - 1) m_drop++;
                end else m_fifo.push_back(sample_in);
            end
        end
    end

    // compare every cycle against the model and log accepted bytes
    always @(negedge clk) begin
        if (armed) begin
            chk("tx_valid", 32'(tx_valid), 32'(m_bytes.size() > 0));
            if (m_bytes.size() > 0) chk("tx_data", 32'(tx_data), 32'(m_bytes[0]));
            chk("fifo_level", 32'(fifo_level), 32'(m_fifo.size()));
            chk("overflow", 32'(overflow), 32'(m_ovf));
            chk("drop_count", 32'(drop_count), 32'(m_drop));
            if (tx_valid && tx_ready) begin
                q_out.push_back(tx_data);
                q_cyc.push_back(cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [17:0] s);
        sample_in = s;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((m_fifo.size() > 0 || m_bytes.size() > 0) && n < 1000) begin
            tick();
            n++;
        end
        if (n >= 1000) timeout("drain");
        tick();
        tick();
    endtask

    task automatic wait_bytes(input int left, input string name);
        int n = 0;
        while (m_bytes.size() != left && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) timeout(name);
    endtask

    initial begin
        int t0;
        int off;
        int cnt;
`ifdef SAMPLE_PACKER_SYNC_EN
        off = 1;
`else
        off = 0;
`endif
        do_reset();
        chk("reset_tx_valid", 32'(tx_valid), 0);
        chk("reset_tx_data", 32'(tx_data), 0);
        chk("reset_level", 32'(fifo_level), 0);
        chk("reset_overflow", 32'(overflow), 0);
        chk("reset_drop", 32'(drop_count), 0);

        // single sample, latency and byte format
        tx_ready = 1'b1;
        q_out.delete();
        q_cyc.delete();
        t0 = cyc;
        send(18'h2ABCD);
        drain();
        chk("t1_count", 32'(q_out.size()), 32'(3 + off));
        if (off == 1) chk("t1_sync", 32'(q_out[0]), 32'hFF);
        chk("t1_b0", 32'(q_out[off]), 32'hAA);
        chk("t1_b1", 32'(q_out[off + 1]), 32'h2F);
        chk("t1_b2", 32'(q_out[off + 2]), 32'h4D);
        chk("t1_latency", 32'(q_cyc[0]), 32'(t0 + 2));

        // stall during B1
        q_out.delete();
        send(18'h12345);
        wait_bytes(2, "t2_reach_b1");
        tx_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk("t2_hold_valid", 32'(tx_valid), 1);
            chk("t2_hold_data", 32'(tx_data), 32'h0D);
            tick();
        end
        tx_ready = 1'b1;
        drain();
        chk("t2_count", 32'(q_out.size()), 3);
        chk("t2_b0", 32'(q_out[0]), 32'h92);
        chk("t2_b1", 32'(q_out[1]), 32'h0D);
        chk("t2_b2", 32'(q_out[2]), 32'h45);

        // burst into a stalled packer
        do_reset();
        tx_ready = 1'b0;
        send(18'h00001);
        tick();
        for (int i = 0; i < DEPTH + 3; i++) begin
            sample_in = 18'(i * 18'h1111 + 5);
            sample_valid = 1'b1;
            tick();
        end
        sample_valid = 1'b0;
        chk("t3_level", 32'(fifo_level), 16);
        chk("t3_overflow", 32'(overflow), 1);
        chk("t3_drop", 32'(drop_count), 3);
        q_out.delete();
        tx_ready = 1'b1;
        drain();
        cnt = 0;
        foreach (q_out[i]) if (q_out[i][7:6] == 2'b10) cnt++;
        chk("t3_samples_out", 32'(cnt), 32'(DEPTH + 1));

        // push and pop in the same cycle while full
        do_reset();
        tx_ready = 1'b0;
        send(18'h00002);
        tick();
        for (int i = 0; i < DEPTH; i++) send(18'(18'h20000 + i));
        chk("t4_full_level", 32'(fifo_level), 16);
        tx_ready = 1'b1;
        wait_bytes(0, "t4_reach_idle");
        sample_in = 18'h3FFFF;
        sample_valid = 1'b1;
        tx_ready = 1'b0;
        tick();
        sample_valid = 1'b0;
        chk("t4_level", 32'(fifo_level), 15);
        chk("t4_drop", 32'(drop_count), 1);
        chk("t4_overflow", 32'(overflow), 1);
        tx_ready = 1'b1;
        drain();

        // frame sync placement over 9 samples
        do_reset();
        tx_ready = 1'b1;
        q_out.delete();
        for (int i = 0; i < 9; i++) send(18'(18'h01040 * (i + 1)));
        drain();
        cnt = 0;
        foreach (q_out[i]) if (q_out[i] == 8'hFF) cnt++;
`ifdef SAMPLE_PACKER_SYNC_EN
        chk("t5_count", 32'(q_out.size()), 30);
        chk("t5_syncs", 32'(cnt), 3);
        chk("t5_sync0", 32'(q_out[0]), 32'hFF);
        chk("t5_sync4", 32'(q_out[13]), 32'hFF);
        chk("t5_sync8", 32'(q_out[26]), 32'hFF);
`else
        chk("t5_count", 32'(q_out.size()), 27);
        chk("t5_syncs", 32'(cnt), 0);
`endif

        // reset during B1 with samples buffered
        do_reset();
        tx_ready = 1'b0;
        for (int i = 0; i < 6; i++) send(18'(18'h00100 + i));
        tx_ready = 1'b1;
        wait_bytes(2, "t6_reach_b1");
        tx_ready = 1'b0;
        chk("t6_level_before", 32'(fifo_level), 5);
        chk("t6_in_b1", 32'(tx_data), 32'h04);
        rst = 1'b1;
        tick();
        chk("t6_rst_valid", 32'(tx_valid), 0);
        chk("t6_rst_data", 32'(tx_data), 0);
        chk("t6_rst_level", 32'(fifo_level), 0);
        chk("t6_rst_overflow", 32'(overflow), 0);
        chk("t6_rst_drop", 32'(drop_count), 0);
        rst = 1'b0;
        tx_ready = 1'b1;
        q_out.delete();
        send(18'h2ABCD);
        drain();
        chk("t6_first", 32'(q_out[0]), off == 1 ? 32'hFF : 32'hAA);
        chk("t6_count", 32'(q_out.size()), 32'(3 + off));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1);
    end
endmodule
